// File: rtl/usb_ep0_setup_decoder.sv
// EP0 SETUP-stage decoder: accepts SETUP tokens for this device on EP0,
// collects the 8-byte setup payload, classifies the standard request and
// issues a single ACK/STALL handshake plus address/configuration strobes.
module usb_ep0_setup_decoder #(
  parameter int MAX_CFG = 1,
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pkt_valid,
  input  logic [3:0]  pkt_pid,
  input  logic [6:0]  pkt_addr,
  input  logic [3:0]  pkt_ep,
  input  logic        data_valid,
  input  logic [7:0]  data,
  input  logic        crc_err,
  input  logic [6:0]  dev_addr,
  output logic        resp_valid,
  output logic [3:0]  resp_pid,
  output logic        req_valid,
  output logic [2:0]  req_code,
  output logic [7:0]  bm_request_type,
  output logic [7:0]  b_request,
  output logic [15:0] w_value,
  output logic [15:0] w_index,
  output logic [15:0] w_length,
  output logic        set_addr_strobe,
  output logic [6:0]  set_addr_value,
  output logic [7:0]  cfg_value,
  output logic        ep0_stalled,
  output logic        busy
);

  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_STALL = 4'hE;

  localparam logic [2:0] RC_NONE        = 3'd0;
  localparam logic [2:0] RC_GET_STATUS  = 3'd1;
  localparam logic [2:0] RC_FEATURE     = 3'd2;
  localparam logic [2:0] RC_SET_ADDRESS = 3'd3;
  localparam logic [2:0] RC_GET_DESC    = 3'd4;
  localparam logic [2:0] RC_GET_CFG     = 3'd5;
  localparam logic [2:0] RC_SET_CFG     = 3'd6;

  // Abort happens on the edge that completes the TIMEOUT-th idle cycle.
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);
  localparam logic [7:0] CFG_MAX = 8'(MAX_CFG);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COLLECT = 2'd1,
    S_DECODE  = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  state_t      r_state;
  logic [2:0]  r_idx;
  logic [7:0]  r_tcnt;
  logic [7:0]  r_buf [8];

  logic        r_resp_valid;
  logic [3:0]  r_resp_pid;
  logic        r_req_valid;
  logic [2:0]  r_req_code;
  logic [7:0]  r_bmrt;
  logic [7:0]  r_breq;
  logic [15:0] r_wval;
  logic [15:0] r_widx;
  logic [15:0] r_wlen;
  logic        r_set_addr_strobe;
  logic [6:0]  r_set_addr_value;
  logic [7:0]  r_cfg_value;
  logic        r_ep0_stalled;

  logic        w_setup_hit;
  logic        w_store;
  logic [15:0] w_buf_wval;
  logic [15:0] w_buf_widx;
  logic [15:0] w_buf_wlen;
  logic [2:0]  w_code;

  // Classify a standard request; anything not explicitly supported is 0.
  function automatic logic [2:0] f_decode(
    input logic [7:0]  bmrt,
    input logic [7:0]  breq,
    input logic [15:0] wval,
    input logic [15:0] widx,
    input logic [15:0] wlen
  );
    logic [2:0] code;
    code = RC_NONE;
    if (bmrt[6:5] == 2'b00) begin
      case (breq)
        8'h00: if (bmrt == 8'h80 || bmrt == 8'h81 || bmrt == 8'h82) code = RC_GET_STATUS;
        8'h01,
        8'h03: if (bmrt == 8'h00 || bmrt == 8'h01 || bmrt == 8'h02) code = RC_FEATURE;
        8'h05: if (bmrt == 8'h00 && wval <= 16'd127 && widx == 16'd0 && wlen == 16'd0)
                 code = RC_SET_ADDRESS;
        8'h06: if (bmrt == 8'h80) code = RC_GET_DESC;
        8'h08: if (bmrt == 8'h80) code = RC_GET_CFG;
        8'h09: if (bmrt == 8'h00 && wval[15:8] == 8'h00 && wval[7:0] <= CFG_MAX)
                 code = RC_SET_CFG;
        default: code = RC_NONE;
      endcase
    end
    return code;
  endfunction

  assign w_setup_hit = pkt_valid & ~data_valid & (pkt_pid == PID_SETUP) &
                       (pkt_addr == dev_addr) & (pkt_ep == 4'd0);
  assign w_store     = (r_state == S_COLLECT) & data_valid & ~crc_err;
  assign w_buf_wval  = {r_buf[3], r_buf[2]};
  assign w_buf_widx  = {r_buf[5], r_buf[4]};
  assign w_buf_wlen  = {r_buf[7], r_buf[6]};
  assign w_code      = f_decode(r_buf[0], r_buf[1], w_buf_wval, w_buf_widx, w_buf_wlen);

  // Payload byte buffer; only published to the outputs in DECODE, so it needs no reset.
  always_ff @(posedge clk) begin
    if (w_store) r_buf[r_idx] <= data;
  end

  // Control FSM with registered handshake, field and side-effect outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state           <= S_IDLE;
      r_idx             <= 3'd0;
      r_tcnt            <= 8'd0;
      r_resp_valid      <= 1'b0;
      r_resp_pid        <= 4'd0;
      r_req_valid       <= 1'b0;
      r_req_code        <= 3'd0;
      r_bmrt            <= 8'd0;
      r_breq            <= 8'd0;
      r_wval            <= 16'd0;
      r_widx            <= 16'd0;
      r_wlen            <= 16'd0;
      r_set_addr_strobe <= 1'b0;
      r_set_addr_value  <= 7'd0;
      r_cfg_value       <= 8'd0;
      r_ep0_stalled     <= 1'b0;
    end else begin
      r_resp_valid      <= 1'b0;
      r_req_valid       <= 1'b0;
      r_set_addr_strobe <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_setup_hit) begin
            r_state       <= S_COLLECT;
            r_idx         <= 3'd0;
            r_tcnt        <= 8'd0;
            r_ep0_stalled <= 1'b0;
          end
        end
        S_COLLECT: begin
          if (data_valid) begin
            if (crc_err) begin
              r_state <= S_IDLE;
            end else begin
              r_tcnt <= 8'd0;
              r_idx  <= r_idx + 3'd1;
              if (r_idx == 3'd7) r_state <= S_DECODE;
            end
          end else if (w_setup_hit) begin
            // A fresh SETUP supersedes the partial payload.
            r_idx         <= 3'd0;
            r_tcnt        <= 8'd0;
            r_ep0_stalled <= 1'b0;
          end else if (r_tcnt >= TO_LAST) begin
            r_state <= S_IDLE;
          end else if (r_tcnt != 8'hFF) begin
            r_tcnt <= r_tcnt + 8'd1;
          end
        end
        S_DECODE: begin
          r_req_code <= w_code;
          r_resp_pid <= (w_code != RC_NONE) ? PID_ACK : PID_STALL;
          r_bmrt     <= r_buf[0];
          r_breq     <= r_buf[1];
          r_wval     <= w_buf_wval;
          r_widx     <= w_buf_widx;
          r_wlen     <= w_buf_wlen;
          r_state    <= S_RESP;
        end
        S_RESP: begin
          r_resp_valid <= 1'b1;
          r_req_valid  <= 1'b1;
          if (r_req_code == RC_SET_ADDRESS) begin
            r_set_addr_strobe <= 1'b1;
            r_set_addr_value  <= r_wval[6:0];
          end
          if (r_req_code == RC_SET_CFG) r_cfg_value <= r_wval[7:0];
          if (r_req_code == RC_NONE) r_ep0_stalled <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid      = r_resp_valid;
  assign resp_pid        = r_resp_pid;
  assign req_valid       = r_req_valid;
  assign req_code        = r_req_code;
  assign bm_request_type = r_bmrt;
  assign b_request       = r_breq;
  assign w_value         = r_wval;
  assign w_index         = r_widx;
  assign w_length        = r_wlen;
  assign set_addr_strobe = r_set_addr_strobe;
  assign set_addr_value  = r_set_addr_value;
  assign cfg_value       = r_cfg_value;
  assign ep0_stalled     = r_ep0_stalled;
  assign busy            = (r_state != S_IDLE);

endmodule

// File: tb/tb_usb_ep0_setup_decoder.sv
// Testbench for usb_ep0_setup_decoder: directed scenarios followed by
// randomized requests, checked against a request-level reference model.
module tb_usb_ep0_setup_decoder;

  localparam int MAX_CFG = 1;
  localparam int TIMEOUT = 64;
  localparam logic [3:0] PID_SETUP = 4'hD;
  localparam logic [3:0] PID_ACK   = 4'h2;
  localparam logic [3:0] PID_STALL = 4'hE;

  logic        clk;
  logic        rst_n;
  logic        pkt_valid;
  logic [3:0]  pkt_pid;
  logic [6:0]  pkt_addr;
  logic [3:0]  pkt_ep;
  logic        data_valid;
  logic [7:0]  data;
  logic        crc_err;
  logic [6:0]  dev_addr;
  logic        resp_valid;
  logic [3:0]  resp_pid;
  logic        req_valid;
  logic [2:0]  req_code;
  logic [7:0]  bm_request_type;
  logic [7:0]  b_request;
  logic [15:0] w_value;
  logic [15:0] w_index;
  logic [15:0] w_length;
  logic        set_addr_strobe;
  logic [6:0]  set_addr_value;
  logic [7:0]  cfg_value;
  logic        ep0_stalled;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;

  logic [7:0]  pl [8];
  logic [7:0]  exp_cfg;
  logic        exp_stall;
  logic [15:0] last_wv, last_wl;

  usb_ep0_setup_decoder #(.MAX_CFG(MAX_CFG), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .pkt_valid(pkt_valid), .pkt_pid(pkt_pid), .pkt_addr(pkt_addr), .pkt_ep(pkt_ep),
    .data_valid(data_valid), .data(data), .crc_err(crc_err), .dev_addr(dev_addr),
    .resp_valid(resp_valid), .resp_pid(resp_pid), .req_valid(req_valid), .req_code(req_code),
    .bm_request_type(bm_request_type), .b_request(b_request),
    .w_value(w_value), .w_index(w_index), .w_length(w_length),
    .set_addr_strobe(set_addr_strobe), .set_addr_value(set_addr_value),
    .cfg_value(cfg_value), .ep0_stalled(ep0_stalled), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic idle_quiet(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      tick();
      chk(tag, resp_valid, 1'b0);
    end
  endtask

  task automatic tok(input logic [6:0] a, input logic [3:0] e, input logic [3:0] p);
    pkt_valid = 1'b1; pkt_addr = a; pkt_ep = e; pkt_pid = p;
    tick();
    pkt_valid = 1'b0; pkt_addr = 7'd0; pkt_ep = 4'd0; pkt_pid = 4'd0;
  endtask

  task automatic accepted_token(input string tag);
    tok(dev_addr, 4'd0, PID_SETUP);
    exp_stall = 1'b0;
    chk({tag, "_tok_busy"}, busy, 1'b1);
    chk({tag, "_tok_stall_clr"}, ep0_stalled, 1'b0);
  endtask

  task automatic send_byte(input logic [7:0] d, input logic c);
    data_valid = 1'b1; data = d; crc_err = c;
    tick();
    data_valid = 1'b0; data = 8'd0; crc_err = 1'b0;
  endtask

  task automatic send_payload(input bit rnd_gaps, input int first, input int last);
    for (int i = first; i <= last; i++) begin
      if (rnd_gaps && i > first) idle($urandom_range(0, 2));
      send_byte(pl[i], 1'b0);
    end
  endtask

  task automatic set_pl(input logic [63:0] v);
    for (int i = 0; i < 8; i++) pl[i] = v[63 - 8*i -: 8];
  endtask

  // Request classification straight from the standard-request rules.
  function automatic logic [2:0] ref_code();
    logic [15:0] wv, wi, wl;
    wv = {pl[3], pl[2]};
    wi = {pl[5], pl[4]};
    wl = {pl[7], pl[6]};
    if (pl[0][6:5] != 2'b00) return 3'd0;
    if (pl[1] == 8'h00 && pl[0] inside {8'h80, 8'h81, 8'h82}) return 3'd1;
    if (pl[1] inside {8'h01, 8'h03} && pl[0] inside {8'h00, 8'h01, 8'h02}) return 3'd2;
    if (pl[1] == 8'h05 && pl[0] == 8'h00 && wv < 16'd128 && wi == 16'd0 && wl == 16'd0) return 3'd3;
    if (pl[1] == 8'h06 && pl[0] == 8'h80) return 3'd4;
    if (pl[1] == 8'h08 && pl[0] == 8'h80) return 3'd5;
    if (pl[1] == 8'h09 && pl[0] == 8'h00 && int'(wv) <= MAX_CFG) return 3'd6;
    return 3'd0;
  endfunction

  // Called right after the edge that samples the last payload byte.
  task automatic finish_check(input string tag);
    logic [2:0]  c;
    logic [15:0] wv, wi, wl;
    c  = ref_code();
    wv = {pl[3], pl[2]};
    wi = {pl[5], pl[4]};
    wl = {pl[7], pl[6]};
    chk({tag, "_busy_dec"}, busy, 1'b1);
    tick();
    chk({tag, "_rv_early"}, resp_valid, 1'b0);
    tick();
    if (c == 3'd6) exp_cfg = wv[7:0];
    if (c == 3'd0) exp_stall = 1'b1;
    chk({tag, "_resp_valid"}, resp_valid, 1'b1);
    chk({tag, "_req_valid"}, req_valid, 1'b1);
    chk({tag, "_resp_pid"}, resp_pid, (c != 3'd0) ? PID_ACK : PID_STALL);
    chk({tag, "_req_code"}, req_code, c);
    chk({tag, "_bmrt"}, bm_request_type, pl[0]);
    chk({tag, "_breq"}, b_request, pl[1]);
    chk({tag, "_wvalue"}, w_value, wv);
    chk({tag, "_windex"}, w_index, wi);
    chk({tag, "_wlength"}, w_length, wl);
    chk({tag, "_addr_strobe"}, set_addr_strobe, (c == 3'd3));
    if (c == 3'd3) chk({tag, "_addr_value"}, set_addr_value, wv[6:0]);
    chk({tag, "_cfg"}, cfg_value, exp_cfg);
    chk({tag, "_stalled"}, ep0_stalled, exp_stall);
    chk({tag, "_busy_end"}, busy, 1'b0);
    tick();
    chk({tag, "_rv_pulse"}, resp_valid, 1'b0);
    chk({tag, "_reqv_pulse"}, req_valid, 1'b0);
    chk({tag, "_strobe_pulse"}, set_addr_strobe, 1'b0);
    chk({tag, "_pid_held"}, resp_pid, (c != 3'd0) ? PID_ACK : PID_STALL);
    last_wv = wv;
    last_wl = wl;
    if (c == 3'd3) dev_addr = wv[6:0];
  endtask

  task automatic full_request(input string tag, input bit rnd_gaps);
    accepted_token(tag);
    send_payload(rnd_gaps, 0, 7);
    finish_check(tag);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_resp_valid"}, resp_valid, 1'b0);
    chk({tag, "_resp_pid"}, resp_pid, 4'd0);
    chk({tag, "_req_valid"}, req_valid, 1'b0);
    chk({tag, "_req_code"}, req_code, 3'd0);
    chk({tag, "_bmrt"}, bm_request_type, 8'd0);
    chk({tag, "_breq"}, b_request, 8'd0);
    chk({tag, "_wvalue"}, w_value, 16'd0);
    chk({tag, "_windex"}, w_index, 16'd0);
    chk({tag, "_wlength"}, w_length, 16'd0);
    chk({tag, "_addr_strobe"}, set_addr_strobe, 1'b0);
    chk({tag, "_addr_value"}, set_addr_value, 7'd0);
    chk({tag, "_cfg"}, cfg_value, 8'd0);
    chk({tag, "_stalled"}, ep0_stalled, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
  endtask

  function automatic logic [7:0] pick_bmrt();
    case ($urandom_range(0, 7))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'h02;
      3: return 8'h80;
      4: return 8'h81;
      5: return 8'h82;
      6: return 8'h20;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [7:0] pick_breq();
    case ($urandom_range(0, 8))
      0: return 8'h00;
      1: return 8'h01;
      2: return 8'h03;
      3: return 8'h05;
      4: return 8'h06;
      5: return 8'h08;
      6: return 8'h09;
      7: return 8'hFF;
      default: return 8'($urandom);
    endcase
  endfunction

  initial begin
    rst_n = 1'b0; pkt_valid = 1'b0; pkt_pid = 4'd0; pkt_addr = 7'd0; pkt_ep = 4'd0;
    data_valid = 1'b0; data = 8'd0; crc_err = 1'b0; dev_addr = 7'd0;
    exp_cfg = 8'd0; exp_stall = 1'b0; last_wv = 16'd0; last_wl = 16'd0;
    for (int i = 0; i < 8; i++) pl[i] = 8'd0;

    // Reset state
    idle(3);
    chk_all_zero("rst");
    rst_n = 1'b1;
    idle(2);

    // Unsupported bRequest 0xFF -> STALL
    set_pl(64'h00FF_0000_0000_0000);
    full_request("stall_ff", 1'b0);

    // SET_ADDRESS 0x2A, then the old address is ignored
    set_pl(64'h0005_2A00_0000_0000);
    full_request("set_addr", 1'b0);
    chk("dev_addr_model", dev_addr, 7'h2A);
    tok(7'h00, 4'd0, PID_SETUP);
    chk("ign_old_addr", busy, 1'b0);
    idle(1);
    chk("ign_old_addr2", busy, 1'b0);
    tok(7'h2A, 4'd1, PID_SETUP);
    chk("ign_ep1", busy, 1'b0);
    tok(7'h2A, 4'd0, 4'h1);
    chk("ign_out_pid", busy, 1'b0);

    // SET_CONFIGURATION 1 accepted, 2 rejected
    set_pl(64'h0009_0100_0000_0000);
    full_request("set_cfg1", 1'b1);
    set_pl(64'h0009_0200_0000_0000);
    full_request("set_cfg2", 1'b1);

    // CRC error on byte 4 discards the transfer
    set_pl(64'h8006_0001_0000_1200);
    accepted_token("crc");
    send_payload(1'b0, 0, 3);
    send_byte(pl[4], 1'b1);
    chk("crc_busy", busy, 1'b0);
    idle_quiet("crc_no_resp", 4);
    chk("crc_wvalue_kept", w_value, last_wv);
    chk("crc_wlength_kept", w_length, last_wl);
    full_request("get_desc", 1'b0);

    // Byte timeout after three bytes
    set_pl(64'h8000_0000_0000_0200);
    accepted_token("tmo");
    send_payload(1'b0, 0, 2);
    idle_quiet("tmo_quiet", TIMEOUT - 1);
    chk("tmo_busy_before", busy, 1'b1);
    tick();
    chk("tmo_busy_after", busy, 1'b0);
    idle_quiet("tmo_no_resp", 3);

    // Restart on a new SETUP after byte 5
    set_pl(64'h0009_0100_0000_0000);
    accepted_token("rst_a");
    send_payload(1'b0, 0, 5);
    set_pl(64'h8200_0000_0100_0200);
    full_request("restart", 1'b0);

    // Reset asserted during byte 6
    set_pl(64'h0009_0100_0000_0000);
    accepted_token("rst_mid");
    send_payload(1'b0, 0, 5);
    data_valid = 1'b1; data = pl[6];
    rst_n = 1'b0;
    #1;
    chk_all_zero("rst_mid");
    exp_cfg = 8'd0; exp_stall = 1'b0; dev_addr = 7'd0;
    data_valid = 1'b0; data = 8'd0;
    idle_quiet("rst_hold", 2);
    rst_n = 1'b1;
    idle_quiet("rst_rel", 4);
    chk("rst_rel_busy", busy, 1'b0);
    full_request("post_rst", 1'b0);

    // Randomized requests interleaved with foreign tokens
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 2) == 0) begin
        tok(dev_addr ^ 7'($urandom_range(1, 127)), 4'd0, PID_SETUP);
        chk("rnd_foreign_tok", busy, 1'b0);
      end
      pl[0] = pick_bmrt();
      pl[1] = pick_breq();
      pl[2] = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
      pl[3] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      pl[4] = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
      pl[5] = 8'h00;
      pl[6] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
      pl[7] = 8'h00;
      full_request("rnd", 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
